// File: rtl/sine_pkg.sv
// -----------------------------------------------------------------------------
// sine_pkg
// Shared types and defaults for the sine analyzer block.
//   state_t          : analyzer FSM states (SEARCH, MEASURE)
//   *_DEF            : default sample width, midpoint, hysteresis, counter width
//   smp_max/smp_min  : extrema helpers, operate on a width wide enough for any
//                      supported sample width (callers size-cast in and out)
// -----------------------------------------------------------------------------
package sine_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int MID_DEF    = 128;
    localparam int HYST_DEF   = 4;
    localparam int CNT_W_DEF  = 12;
    localparam int SMP_MAX_W  = 16;

    typedef enum logic {
        SEARCH  = 1'b0,
        MEASURE = 1'b1
    } state_t;

    function automatic logic [SMP_MAX_W-1:0] smp_max(input logic [SMP_MAX_W-1:0] a,
                                                     input logic [SMP_MAX_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [SMP_MAX_W-1:0] smp_min(input logic [SMP_MAX_W-1:0] a,
                                                     input logic [SMP_MAX_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

endpackage

// File: rtl/sine_xdet.sv
// -----------------------------------------------------------------------------
// sine_xdet
// Hysteresis crossing detector. A sample below MID-HYST arms the detector; the
// next accepted sample at or above MID while armed is a rising crossing, which
// disarms it. Samples in [MID-HYST, MID) leave the armed bit untouched.
// Ports:
//   clk, reset (async, active-low), data (sample valid), sine_in (sample)
//   clr   : disarm on this accepted sample regardless of its value
//   xing  : combinational crossing flag for the current sample
//   armed : registered armed bit
// -----------------------------------------------------------------------------
module sine_xdet
    import sine_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int MID    = MID_DEF,
    parameter int HYST   = HYST_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data,
    input  logic              clr,
    input  logic [DATA_W-1:0] sine_in,
    output logic              xing,
    output logic              armed
);

    localparam logic [DATA_W-1:0] MID_V = DATA_W'(MID);
    localparam logic [DATA_W-1:0] ARM_V = DATA_W'(MID - HYST);

    logic r_armed;

    assign xing  = data & r_armed & (sine_in >= MID_V);
    assign armed = r_armed;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_armed <= 1'b0;
        end else if (data) begin
            if (clr || xing) begin
                r_armed <= 1'b0;
            end else if (sine_in < ARM_V) begin
                r_armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sine_analyzer.sv
// -----------------------------------------------------------------------------
// sine_analyzer
// Measures period (in accepted samples), peak, trough and peak-to-peak amplitude
// of an unsigned sample stream between consecutive rising midpoint crossings,
// and flags lock once LOCK_COUNT consecutive periods agree within TOL.
// Ports:
//   clk, reset (async, active-low)
//   data       : sample valid; all state holds while low
//   sine_in    : sample value
//   period_out : last measured period
//   peak_out   : max sample of last period
//   trough_out : min sample of last period
//   amp_out    : peak_out - trough_out
//   meas_stb   : one-cycle pulse when the four measurements update
//   locked     : periods stable
//   ovf        : one-cycle pulse when the period counter saturates
// States:
//   SEARCH  | waiting for the first crossing; no period in progress
//   MEASURE | counting samples and tracking extrema of the current period
// -----------------------------------------------------------------------------
module sine_analyzer
    import sine_pkg::*;
#(
    parameter int DATA_W     = DATA_W_DEF,
    parameter int MID        = MID_DEF,
    parameter int HYST       = HYST_DEF,
    parameter int CNT_W      = CNT_W_DEF,
    parameter int LOCK_COUNT = 2,
    parameter int TOL        = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              data,
    input  logic [DATA_W-1:0] sine_in,
    output logic [CNT_W-1:0]  period_out,
    output logic [DATA_W-1:0] peak_out,
    output logic [DATA_W-1:0] trough_out,
    output logic [DATA_W-1:0] amp_out,
    output logic              meas_stb,
    output logic              locked,
    output logic              ovf
);

    localparam int                 MW      = $clog2(LOCK_COUNT + 1);
    localparam int                 CW1     = CNT_W + 1;
    localparam logic [CNT_W-1:0]   CNT_MAX = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [MW-1:0]      LOCK_V  = MW'(LOCK_COUNT);
    localparam logic signed [CNT_W:0] TOL_V = CW1'(TOL);

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_pk;
    logic [DATA_W-1:0] r_tr;
    logic [CNT_W-1:0]  r_prev;
    logic              r_have_prev;
    logic [MW-1:0]     r_match_cnt;
    logic [CNT_W-1:0]  r_period;
    logic [DATA_W-1:0] r_peak;
    logic [DATA_W-1:0] r_trough;
    logic [DATA_W-1:0] r_amp;
    logic              r_stb;
    logic              r_locked;
    logic              r_ovf;

    logic              w_xing;
    logic              w_armed;
    logic              w_cross;
    logic              w_ovf_hit;
    logic signed [CNT_W:0] w_diff;
    logic signed [CNT_W:0] w_abs;
    logic              w_match;
    logic [MW-1:0]     w_match_nxt;

    sine_xdet #(
        .DATA_W (DATA_W),
        .MID    (MID),
        .HYST   (HYST)
    ) u_xdet (
        .clk     (clk),
        .reset   (reset),
        .data    (data),
        .clr     (w_ovf_hit),
        .sine_in (sine_in),
        .xing    (w_xing),
        .armed   (w_armed)
    );

    assign w_cross   = w_xing & w_armed;
    assign w_ovf_hit = data & (r_state == MEASURE) & ~w_cross & (r_cnt == CNT_MAX);

    // Period difference is signed one bit wider than the counter so that
    // shorter-than-previous periods compare correctly.
    assign w_diff  = $signed({1'b0, r_cnt}) - $signed({1'b0, r_prev});
    assign w_abs   = (w_diff < 0) ? -w_diff : w_diff;
    assign w_match = r_have_prev & (w_abs <= TOL_V);

    always_comb begin
        w_match_nxt = '0;
        if (w_match) begin
            w_match_nxt = (r_match_cnt < LOCK_V) ? r_match_cnt + 1'b1 : r_match_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= SEARCH;
            r_cnt       <= '0;
            r_pk        <= '0;
            r_tr        <= '0;
            r_prev      <= '0;
            r_have_prev <= 1'b0;
            r_match_cnt <= '0;
            r_period    <= '0;
            r_peak      <= '0;
            r_trough    <= '0;
            r_amp       <= '0;
            r_stb       <= 1'b0;
            r_locked    <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_stb <= 1'b0;
            r_ovf <= 1'b0;
            if (data) begin
                case (r_state)
                    SEARCH: begin
                        if (w_cross) begin
                            r_state <= MEASURE;
                            r_cnt   <= CNT_ONE;
                            r_pk    <= sine_in;
                            r_tr    <= sine_in;
                        end
                    end
                    MEASURE: begin
                        if (w_cross) begin
                            // Crossing sample opens the next period, so the
                            // reported extrema exclude it.
                            r_period    <= r_cnt;
                            r_peak      <= r_pk;
                            r_trough    <= r_tr;
                            r_amp       <= r_pk - r_tr;
                            r_stb       <= 1'b1;
                            r_match_cnt <= w_match_nxt;
                            r_locked    <= (w_match_nxt >= LOCK_V);
                            r_prev      <= r_cnt;
                            r_have_prev <= 1'b1;
                            r_cnt       <= CNT_ONE;
                            r_pk        <= sine_in;
                            r_tr        <= sine_in;
                        end else if (w_ovf_hit) begin
                            r_ovf       <= 1'b1;
                            r_locked    <= 1'b0;
                            r_match_cnt <= '0;
                            r_have_prev <= 1'b0;
                            r_state     <= SEARCH;
                            r_cnt       <= '0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            r_pk  <= DATA_W'(smp_max(SMP_MAX_W'(r_pk), SMP_MAX_W'(sine_in)));
                            r_tr  <= DATA_W'(smp_min(SMP_MAX_W'(r_tr), SMP_MAX_W'(sine_in)));
                        end
                    end
                    default: r_state <= SEARCH;
                endcase
            end
        end
    end

    assign period_out = r_period;
    assign peak_out   = r_peak;
    assign trough_out = r_trough;
    assign amp_out    = r_amp;
    assign meas_stb   = r_stb;
    assign locked     = r_locked;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_sine_analyzer.sv
// -----------------------------------------------------------------------------
// tb_sine_analyzer
// Directed stimulus against a sample-history model: the model keeps the samples
// of the period in progress and the list of reported periods, and derives every
// output from those each accepted sample. A negedge monitor compares all
// outputs against the model every cycle; literal checks pin key results.
// -----------------------------------------------------------------------------
module tb_sine_analyzer;

    localparam int DATA_W     = 8;
    localparam int MID        = 128;
    localparam int HYST       = 4;
    localparam int CNT_W      = 12;
    localparam int LOCK_COUNT = 2;
    localparam int TOL        = 1;
    localparam int CNT_MAXI   = (1 << CNT_W) - 1;

    logic              clk     = 1'b0;
    logic              reset   = 1'b1;
    logic              data    = 1'b0;
    logic [DATA_W-1:0] sine_in = '0;

    wire [CNT_W-1:0]  period_out;
    wire [DATA_W-1:0] peak_out;
    wire [DATA_W-1:0] trough_out;
    wire [DATA_W-1:0] amp_out;
    wire              meas_stb;
    wire              locked;
    wire              ovf;

    always #5 clk = ~clk;

    sine_analyzer #(
        .DATA_W     (DATA_W),
        .MID        (MID),
        .HYST       (HYST),
        .CNT_W      (CNT_W),
        .LOCK_COUNT (LOCK_COUNT),
        .TOL        (TOL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .data       (data),
        .sine_in    (sine_in),
        .period_out (period_out),
        .peak_out   (peak_out),
        .trough_out (trough_out),
        .amp_out    (amp_out),
        .meas_stb   (meas_stb),
        .locked     (locked),
        .ovf        (ovf)
    );

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    // model state and expected outputs
    int e_period, e_peak, e_trough, e_amp;
    bit e_stb, e_locked, e_ovf;
    bit m_armed, m_in;
    int q_smp[$];
    int m_rep[$];

    // observed events
    int stb_per[$];
    bit stb_lock[$];
    int ovf_cnt = 0;

    task automatic check(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            if (bad <= 25)
                $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        e_period = 0; e_peak = 0; e_trough = 0; e_amp = 0;
        e_stb = 0; e_locked = 0; e_ovf = 0;
        m_armed = 0; m_in = 0;
        q_smp.delete();
        m_rep.delete();
    endtask

    task automatic model_step(input bit d, input int s);
        bit xing;
        int pk, tr, n, df;
        e_stb = 0;
        e_ovf = 0;
        if (!d) return;
        xing = m_armed && (s >= MID);
        if (m_in && !xing && q_smp.size() == CNT_MAXI) begin
            e_ovf = 1; e_locked = 0;
            m_rep.delete(); q_smp.delete();
            m_in = 0; m_armed = 0;
            return;
        end
        if (xing) begin
            m_armed = 0;
            if (m_in) begin
                pk = q_smp[0]; tr = q_smp[0];
                foreach (q_smp[k]) begin
                    if (q_smp[k] > pk) pk = q_smp[k];
                    if (q_smp[k] < tr) tr = q_smp[k];
                end
                e_period = q_smp.size(); e_peak = pk; e_trough = tr; e_amp = pk - tr;
                e_stb = 1;
                m_rep.push_back(e_period);
                n = m_rep.size();
                e_locked = 0;
                if (n >= LOCK_COUNT + 1) begin
                    e_locked = 1;
                    for (int k = 0; k < LOCK_COUNT; k++) begin
                        df = m_rep[n-1-k] - m_rep[n-2-k];
                        if (df < 0) df = -df;
                        if (df > TOL) e_locked = 0;
                    end
                end
            end
            m_in = 1;
            q_smp.delete();
            q_smp.push_back(s);
        end else begin
            if (s < MID - HYST) m_armed = 1;
            if (m_in) q_smp.push_back(s);
        end
    endtask

    task automatic drive(input bit d, input int s);
        data    = d;
        sine_in = DATA_W'(s);
        @(posedge clk);
        model_step(d, s);
        #1;
    endtask

    task automatic pulse_reset();
        data  = 1'b0;
        reset = 1'b0;
        model_clear();
        #1;
        check("rst_period", period_out, 0);
        check("rst_peak",   peak_out,   0);
        check("rst_trough", trough_out, 0);
        check("rst_amp",    amp_out,    0);
        check("rst_stb",    meas_stb,   0);
        check("rst_locked", locked,     0);
        check("rst_ovf",    ovf,        0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    // hi x 200 then lo x 50, repeated; with gaps, 3 invalid cycles carrying a
    // low (would-arm) value are inserted after every 5 accepted samples
    task automatic sq(input int hi, input int lo, input int reps, input bit gaps);
        int acc = 0;
        for (int r = 0; r < reps; r++) begin
            for (int i = 0; i < hi + lo; i++) begin
                drive(1'b1, (i < hi) ? 200 : 50);
                acc++;
                if (gaps && (acc % 5 == 0)) begin
                    repeat (3) drive(1'b0, 7);
                end
            end
        end
    endtask

    task automatic clear_obs();
        stb_per.delete();
        stb_lock.delete();
        ovf_cnt = 0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("period_out", period_out, e_period);
                check("peak_out",   peak_out,   e_peak);
                check("trough_out", trough_out, e_trough);
                check("amp_out",    amp_out,    e_amp);
                check("meas_stb",   meas_stb,   e_stb);
                check("locked",     locked,     e_locked);
                check("ovf",        ovf,        e_ovf);
                if (meas_stb) begin
                    stb_per.push_back(int'(period_out));
                    stb_lock.push_back(locked);
                end
                if (ovf) ovf_cnt++;
            end
        end
    end

    initial begin
        model_clear();
        #1 reset = 1'b0;
        #20;
        check("init_period", period_out, 0);
        check("init_locked", locked, 0);
        check("init_stb", meas_stb, 0);
        @(posedge clk);
        #1;
        reset  = 1'b1;
        chk_en = 1'b1;

        // square wave, period 16
        clear_obs();
        sq(8, 8, 5, 1'b0);
        check("sq_nrep",   stb_per.size(), 3);
        check("sq_per0",   stb_per[0], 16);
        check("sq_peak",   peak_out, 200);
        check("sq_trough", trough_out, 50);
        check("sq_amp",    amp_out, 150);
        check("sq_lock1",  stb_lock[1], 0);
        check("sq_lock2",  stb_lock[2], 1);

        // same wave with invalid gaps
        pulse_reset();
        clear_obs();
        sq(8, 8, 5, 1'b1);
        check("gap_nrep", stb_per.size(), 3);
        check("gap_per",  period_out, 16);
        check("gap_amp",  amp_out, 150);
        check("gap_lock", locked, 1);

        // noise inside the hysteresis band never arms
        pulse_reset();
        clear_obs();
        for (int i = 0; i < 100; i++) begin
            drive(1'b1, 127);
            drive(1'b1, 129);
        end
        check("noise_nrep", stb_per.size(), 0);
        check("noise_lock", locked, 0);

        // period change 16 -> 20
        pulse_reset();
        sq(8, 8, 5, 1'b0);
        clear_obs();
        sq(10, 10, 4, 1'b0);
        check("chg_nrep",  stb_per.size(), 4);
        check("chg_per0",  stb_per[0], 16);
        check("chg_per1",  stb_per[1], 20);
        check("chg_per3",  stb_per[3], 20);
        check("chg_lock0", stb_lock[0], 1);
        check("chg_lock1", stb_lock[1], 0);
        check("chg_lock2", stb_lock[2], 0);
        check("chg_lock3", stb_lock[3], 1);

        // overflow, then relock
        pulse_reset();
        sq(8, 8, 5, 1'b0);
        check("ovf_prelock", locked, 1);
        clear_obs();
        repeat (4100) drive(1'b1, 200);
        check("ovf_count", ovf_cnt, 1);
        check("ovf_lock",  locked, 0);
        check("ovf_keep",  period_out, 16);
        clear_obs();
        sq(8, 8, 5, 1'b0);
        check("relock_nrep", stb_per.size(), 3);
        check("relock",      locked, 1);

        // reset mid-period
        pulse_reset();
        sq(8, 8, 5, 1'b0);
        repeat (4) drive(1'b1, 200);
        check("mid_pre_per", period_out, 16);
        pulse_reset();
        clear_obs();
        sq(8, 8, 3, 1'b0);
        check("mid_nrep",   stb_per.size(), 1);
        check("mid_per",    stb_per[0], 16);
        check("mid_peak",   peak_out, 200);
        check("mid_trough", trough_out, 50);
        check("mid_lock",   locked, 0);

        repeat (2) drive(1'b0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
